// File: rtl/matrix_loader.sv
// Stream loader: header + A/B words into RAM, then kicks the multiplier.
// Optional macro LOADER_HDR_CHECK_EN enables header dimension/capacity checks.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_start               begin a load transaction (IDLE only)
//   in_data/in_valid/in_ready  word stream handshake
//   ram_we/ram_addr/ram_w_data registered RAM write port
//   start_mul                one-cycle multiplier start
//   mul_done/mul_err         multiplier completion / dimension error
//   busy                     state is not IDLE
//   load_done/err            one-cycle completion / failure pulses
module matrix_loader #(
  parameter int data_w    = 32,
  parameter int ram_d     = 512,
  parameter int ram_add_w = $clog2(ram_d),
  parameter int d_w_q     = data_w/4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [data_w-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 ram_we,
  output logic [ram_add_w-1:0] ram_addr,
  output logic [data_w-1:0]    ram_w_data,
  output logic                 start_mul,
  input  logic                 mul_done,
  input  logic                 mul_err,
  output logic                 busy,
  output logic                 load_done,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE, HDR, META, LOAD, KICK, WAIT
  } st_t;

  localparam int cw = ram_add_w + 1;
  typedef logic [cw-1:0]        cnt_t;
  typedef logic [2*d_w_q-1:0]   prod_t;
  typedef logic [3:0][d_w_q-1:0] dims_t;

  st_t   state, state_n;
  cnt_t  idx, idx_n;
  dims_t dims, dims_n;

  logic                 rdy_n;
  logic                 we_n;
  logic [ram_add_w-1:0] addr_n;
  logic [data_w-1:0]    wd_n;
  logic                 start_n;
  logic                 done_n;
  logic                 err_n;

  logic  hs;
  logic  hdr_bad;
  prod_t p1, p2;
  cnt_t  w_cnt;
  cnt_t  wa;

  assign hs    = in_valid & in_ready;
  assign busy  = (state != IDLE);
  assign p1    = prod_t'(dims[3]) * prod_t'(dims[2]);
  assign p2    = prod_t'(dims[1]) * prod_t'(dims[0]);
  assign w_cnt = cnt_t'(p1) + cnt_t'(p2);
  assign wa    = idx + cnt_t'(2);

`ifdef LOADER_HDR_CHECK_EN
  localparam int xw = 2*d_w_q + cw + 4;
  typedef logic [xw-1:0] ext_t;

  ext_t m1e, n2e, need;
  logic zero_dim;

  // Result area uses dimensions rounded up to even.
  assign m1e  = ext_t'(dims[3]) + ext_t'(dims[3][0]);
  assign n2e  = ext_t'(dims[0]) + ext_t'(dims[0][0]);
  assign need = ext_t'(2) + ext_t'(w_cnt) + m1e * n2e;

  assign zero_dim = (dims[3] == '0) || (dims[2] == '0)
                 || (dims[1] == '0) || (dims[0] == '0);

  assign hdr_bad = (dims[2] != dims[1]) || zero_dim
                || (need > ext_t'(ram_d));
`else
  assign hdr_bad = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    dims_n  = dims;
    we_n    = 1'b0;
    addr_n  = ram_addr;
    wd_n    = ram_w_data;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        idx_n = '0;
        if (load_start) state_n = HDR;
      end
      HDR: begin
        if (hs) begin
          dims_n  = in_data[4*d_w_q-1:0];
          we_n    = 1'b1;
          addr_n  = '0;
          wd_n    = in_data;
          state_n = META;
        end
      end
      META: begin
        we_n   = 1'b1;
        addr_n = ram_add_w'(1);
        wd_n   = '0;
        idx_n  = '0;
        if (hdr_bad) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (hs) begin
          we_n   = 1'b1;
          addr_n = wa[ram_add_w-1:0];
          wd_n   = in_data;
          idx_n  = idx + cnt_t'(1);
          if (idx == w_cnt - cnt_t'(1))
            state_n = KICK;
        end
      end
      KICK: begin
        state_n = WAIT;
      end
      WAIT: begin
        // Error has priority over completion.
        if (mul_err) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (mul_done) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Registered from next state so they line up with the state itself.
    rdy_n   = (state_n == HDR) || (state_n == LOAD);
    start_n = (state_n == KICK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      dims       <= '0;
      in_ready   <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_w_data <= '0;
      start_mul  <= 1'b0;
      load_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      dims       <= dims_n;
      in_ready   <= rdy_n;
      ram_we     <= we_n;
      ram_addr   <= addr_n;
      ram_w_data <= wd_n;
      start_mul  <= start_n;
      load_done  <= done_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized self-checking bench for matrix_loader.
// Expected RAM writes and pulses come from a header-arithmetic model.
module tb_matrix_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_w_data;
  logic        start_mul;
  logic        mul_done;
  logic        mul_err;
  logic        busy;
  logic        load_done;
  logic        err;

  int total = 0;
  int bad   = 0;

  int          wa[$];
  logic [31:0] wd[$];
  int          st_cnt = 0;
  int          er_cnt = 0;
  int          dn_cnt = 0;

  matrix_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_w_data (ram_w_data),
    .start_mul  (start_mul),
    .mul_done   (mul_done),
    .mul_err    (mul_err),
    .busy       (busy),
    .load_done  (load_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (ram_we) begin
      wa.push_back(int'(ram_addr));
      wd.push_back(ram_w_data);
    end
    if (start_mul) st_cnt++;
    if (err)       er_cnt++;
    if (load_done) dn_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [31:0] hdr,
                       output int w, output bit ok);
    int m1, n1, m2, n2;
    m1 = int'(hdr[31:24]);
    n1 = int'(hdr[23:16]);
    m2 = int'(hdr[15:8]);
    n2 = int'(hdr[7:0]);
    w  = (m1*n1 + m2*n2) % 1024;
    ok = 1'b1;
`ifdef LOADER_HDR_CHECK_EN
    begin
      int m1e, n2e;
      m1e = m1 + (m1 % 2);
      n2e = n2 + (n2 % 2);
      if (n1 != m2) ok = 1'b0;
      if (m1 == 0 || n1 == 0 || m2 == 0 || n2 == 0) ok = 1'b0;
      if (2 + w > 512 - m1e*n2e) ok = 1'b0;
    end
`endif
  endtask

  task automatic feed(input logic [31:0] words[$], input int nacc,
                      input int mode, output int sent);
    int cyc;
    bit v, hs;
    cyc  = 0;
    sent = 0;
    while (sent < nacc && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = words[sent];
      hs = v && in_ready;
      @(negedge clk);
      if (hs) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("feed_cnt", 64'(sent), 64'(nacc));
  endtask

  task automatic run_load(input logic [31:0] hdr, input int mode,
                          input int resp, input bit seq);
    int          w, nacc, sent, t, k;
    bit          ok;
    logic [31:0] words[$];
    int          ea[$];
    logic [31:0] ed[$];
    int          wb, sb, eb, db;
    model(hdr, w, ok);
    words.push_back(hdr);
    for (int n = 0; n < w; n++)
      words.push_back(seq ? 32'(n + 1) : $urandom);
    ea.push_back(0); ed.push_back(hdr);
    ea.push_back(1); ed.push_back(32'h0);
    if (ok)
      for (int n = 0; n < w; n++) begin
        ea.push_back(2 + n);
        ed.push_back(words[n + 1]);
      end
    nacc = ok ? w + 1 : 1;

    @(negedge clk);
    wb = wa.size(); sb = st_cnt; eb = er_cnt; db = dn_cnt;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    feed(words, nacc, mode, sent);

    if (ok) begin
      t = 0;
      while (!start_mul && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("kick_seen", 64'(start_mul), 64'(1));
      @(negedge clk);
      k = $urandom_range(0, 3);
      repeat (k) begin
        chk("busy_wait", 64'(busy), 64'(1));
        @(negedge clk);
      end
      mul_done = (resp != 1);
      mul_err  = (resp != 0);
      @(negedge clk);
      mul_done = 1'b0;
      mul_err  = 1'b0;
      chk("done_pulse", 64'(load_done), 64'(resp == 0));
      chk("err_pulse", 64'(err), 64'(resp != 0));
    end else begin
      t = 0;
      while (!err && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("hdr_err", 64'(err), 64'(1));
    end

    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("kick_cnt", 64'(st_cnt - sb), 64'(ok));
    chk("err_cnt", 64'(er_cnt - eb), 64'(ok ? (resp != 0) : 1));
    chk("done_cnt", 64'(dn_cnt - db), 64'(ok && resp == 0));
    chk("wr_cnt", 64'(wa.size() - wb), 64'(ea.size()));
    for (int i = 0; i < ea.size() && wb + i < wa.size(); i++) begin
      chk("wr_addr", 64'(wa[wb + i]), 64'(ea[i]));
      chk("wr_data", 64'(wd[wb + i]), 64'(ed[i]));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  64'(busy),       64'(0));
    chk({tag, "_rdy"},   64'(in_ready),   64'(0));
    chk({tag, "_we"},    64'(ram_we),     64'(0));
    chk({tag, "_addr"},  64'(ram_addr),   64'(0));
    chk({tag, "_wdata"}, 64'(ram_w_data), 64'(0));
    chk({tag, "_start"}, 64'(start_mul),  64'(0));
    chk({tag, "_done"},  64'(load_done),  64'(0));
    chk({tag, "_err"},   64'(err),        64'(0));
  endtask

  initial begin
    logic [31:0] rw[$];
    logic [7:0]  a, b, c, d;
    int          sent;
    rst        = 1'b1;
    load_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    mul_done   = 1'b0;
    mul_err    = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;

    run_load(32'h02020202, 0, 0, 1'b1);
    run_load(32'h02030202, 0, 1, 1'b0);
    run_load(32'h03030302, 1, 0, 1'b0);

    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    rw.push_back(32'h02020202);
    for (int n = 0; n < 8; n++) rw.push_back(32'(n + 1));
    feed(rw, 4, 0, sent);
    chk("pre_rst_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    run_load(32'h02020202, 2, 0, 1'b0);

    run_load(32'h02020202, 0, 2, 1'b0);

`ifdef LOADER_HDR_CHECK_EN
    run_load(32'h10101010, 0, 0, 1'b0);
`endif

    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(1, 5));
      b = 8'($urandom_range(1, 5));
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 5)) : b;
      d = 8'($urandom_range(1, 5));
      run_load({a, b, c, d}, $urandom_range(0, 2),
               $urandom_range(0, 2), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
